// File: rtl/secded_dec_pipe_if.sv
// Stream/status bundle for the pipelined SECDED decoder: codeword in, decoded word
// and flags out, plus the error-statistics controls and results.
interface secded_dec_pipe_if #(
    parameter int K     = 8,
    parameter int CNT_W = 16
);
    function automatic int calc_m(input int k);
        int m;
        m = 0;
        for (int i = 1; i < 32; i++) begin
            if (m == 0 && (1 << i) >= i + k + 1) m = i;
        end
        return m;
    endfunction

    localparam int M = calc_m(K);
    localparam int N = M + K;

    logic [N:0]       d_i;
    logic             d_valid_i;
    logic             d_ready_o;
    logic             corr_en_i;
    logic [K-1:0]     q_o;
    logic             q_valid_o;
    logic             q_ready_i;
    logic [M-1:0]     syndrome_o;
    logic             sb_err_o;
    logic             db_err_o;
    logic             sb_fix_o;
    logic             clr_i;
    logic [CNT_W-1:0] sb_cnt_o;
    logic [CNT_W-1:0] db_cnt_o;
    logic [M-1:0]     first_syn_o;
    logic             first_vld_o;

    modport master (
        output d_i, d_valid_i, corr_en_i, q_ready_i, clr_i,
        input  d_ready_o, q_o, q_valid_o, syndrome_o, sb_err_o, db_err_o, sb_fix_o,
               sb_cnt_o, db_cnt_o, first_syn_o, first_vld_o
    );

    modport slave (
        input  d_i, d_valid_i, corr_en_i, q_ready_i, clr_i,
        output d_ready_o, q_o, q_valid_o, syndrome_o, sb_err_o, db_err_o, sb_fix_o,
               sb_cnt_o, db_cnt_o, first_syn_o, first_vld_o
    );
endinterface

// File: rtl/secded_dec_pipe.sv
// Two-stage Hamming SECDED decoder with valid/ready flow control, optional
// single-error correction, saturating error counters and first-error capture.
module secded_dec_pipe #(
    parameter int K     = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    secded_dec_pipe_if.slave bus
);
    function automatic int calc_m(input int k);
        int m;
        m = 0;
        for (int i = 1; i < 32; i++) begin
            if (m == 0 && (1 << i) >= i + k + 1) m = i;
        end
        return m;
    endfunction

    localparam int M = calc_m(K);
    localparam int N = M + K;

    // Hamming position of the idx-th data bit (non-power-of-two positions, ascending).
    function automatic int data_pos(input int idx);
        int cnt;
        int res;
        cnt = 0;
        res = 0;
        for (int p = 1; p <= N; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == idx) res = p;
                cnt++;
            end
        end
        return res;
    endfunction

    function automatic logic [N:0] syn_mask(input int b);
        logic [N:0] m;
        m = '0;
        for (int p = 1; p <= N; p++) begin
            if (((p >> b) & 1) == 1) m[p] = 1'b1;
        end
        return m;
    endfunction

    logic             s1_valid_q, s1_valid_d;
    logic [K-1:0]     s1_data_q, s1_data_d;
    logic [M-1:0]     s1_syn_q, s1_syn_d;
    logic             s1_par_q, s1_par_d;
    logic             s1_corr_q, s1_corr_d;

    logic             s2_valid_q, s2_valid_d;
    logic [K-1:0]     s2_q_q, s2_q_d;
    logic [M-1:0]     s2_syn_q, s2_syn_d;
    logic             s2_sb_q, s2_sb_d;
    logic             s2_db_q, s2_db_d;
    logic             s2_fix_q, s2_fix_d;

    logic [CNT_W-1:0] sb_cnt_q, sb_cnt_d;
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic [M-1:0]     first_syn_q, first_syn_d;
    logic             first_vld_q, first_vld_d;

    logic [K-1:0]     in_data;
    logic [M-1:0]     in_syn;
    logic             in_par;
    logic [K-1:0]     dec_q;
    logic             syn_in_range;
    logic             dec_sb;
    logic             dec_db;
    logic             dec_fix;
    logic             s1_adv;
    logic             s2_adv;
    logic             out_hs;

    assign s2_adv = !s2_valid_q || bus.q_ready_i;
    assign s1_adv = !s1_valid_q || s2_adv;
    assign out_hs = s2_valid_q && bus.q_ready_i;
    assign in_par = ^bus.d_i;

    for (genvar gi = 0; gi < M; gi++) begin : g_syn
        localparam logic [N:0] MASK = syn_mask(gi);
        assign in_syn[gi] = ^(bus.d_i & MASK);
    end

    // Only data positions are kept past S1; a flip at a check/parity position
    // leaves the delivered data unchanged, so it needs no storage.
    for (genvar gi = 0; gi < K; gi++) begin : g_data
        localparam int         DP  = data_pos(gi);
        localparam logic [M-1:0] DPS = M'(DP);
        assign in_data[gi] = bus.d_i[DP];
        assign dec_q[gi]   = s1_data_q[gi] ^ (dec_fix && (s1_syn_q == DPS));
    end

    always_comb begin
        syn_in_range = (int'(s1_syn_q) <= N);
        dec_sb       = s1_par_q && syn_in_range;
        dec_db       = s1_par_q ? !syn_in_range : (s1_syn_q != '0);
        dec_fix      = dec_sb && s1_corr_q;
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_data_d   = s1_data_q;
        s1_syn_d    = s1_syn_q;
        s1_par_d    = s1_par_q;
        s1_corr_d   = s1_corr_q;
        s2_valid_d  = s2_valid_q;
        s2_q_d      = s2_q_q;
        s2_syn_d    = s2_syn_q;
        s2_sb_d     = s2_sb_q;
        s2_db_d     = s2_db_q;
        s2_fix_d    = s2_fix_q;
        sb_cnt_d    = sb_cnt_q;
        db_cnt_d    = db_cnt_q;
        first_syn_d = first_syn_q;
        first_vld_d = first_vld_q;

        if (s1_adv) begin
            s1_valid_d = bus.d_valid_i;
            if (bus.d_valid_i) begin
                s1_data_d = in_data;
                s1_syn_d  = in_syn;
                s1_par_d  = in_par;
                s1_corr_d = bus.corr_en_i;
            end
        end

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_q_d   = dec_q;
                s2_syn_d = s1_syn_q;
                s2_sb_d  = dec_sb;
                s2_db_d  = dec_db;
                s2_fix_d = dec_fix;
            end
        end

        // Clear takes priority over any same-cycle increment or capture.
        if (bus.clr_i) begin
            sb_cnt_d    = '0;
            db_cnt_d    = '0;
            first_syn_d = '0;
            first_vld_d = 1'b0;
        end else if (out_hs) begin
            if (s2_sb_q && sb_cnt_q != {CNT_W{1'b1}}) sb_cnt_d = sb_cnt_q + CNT_W'(1);
            if (s2_db_q && db_cnt_q != {CNT_W{1'b1}}) db_cnt_d = db_cnt_q + CNT_W'(1);
            if ((s2_sb_q || s2_db_q) && !first_vld_q) begin
                first_syn_d = s2_syn_q;
                first_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_syn_q    <= '0;
            s1_par_q    <= 1'b0;
            s1_corr_q   <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_q_q      <= '0;
            s2_syn_q    <= '0;
            s2_sb_q     <= 1'b0;
            s2_db_q     <= 1'b0;
            s2_fix_q    <= 1'b0;
            sb_cnt_q    <= '0;
            db_cnt_q    <= '0;
            first_syn_q <= '0;
            first_vld_q <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_syn_q    <= s1_syn_d;
            s1_par_q    <= s1_par_d;
            s1_corr_q   <= s1_corr_d;
            s2_valid_q  <= s2_valid_d;
            s2_q_q      <= s2_q_d;
            s2_syn_q    <= s2_syn_d;
            s2_sb_q     <= s2_sb_d;
            s2_db_q     <= s2_db_d;
            s2_fix_q    <= s2_fix_d;
            sb_cnt_q    <= sb_cnt_d;
            db_cnt_q    <= db_cnt_d;
            first_syn_q <= first_syn_d;
            first_vld_q <= first_vld_d;
        end
    end

    assign bus.d_ready_o   = s1_adv;
    assign bus.q_o         = s2_q_q;
    assign bus.q_valid_o   = s2_valid_q;
    assign bus.syndrome_o  = s2_syn_q;
    assign bus.sb_err_o    = s2_sb_q;
    assign bus.db_err_o    = s2_db_q;
    assign bus.sb_fix_o    = s2_fix_q;
    assign bus.sb_cnt_o    = sb_cnt_q;
    assign bus.db_cnt_o    = db_cnt_q;
    assign bus.first_syn_o = first_syn_q;
    assign bus.first_vld_o = first_vld_q;
endmodule

// File: tb/tb_secded_dec_pipe.sv
// Directed bench for secded_dec_pipe: K=8 vectors, backpressure stream, clear and
// reset behaviour, plus a CNT_W=2 instance for counter saturation.
module tb_secded_dec_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    secded_dec_pipe_if #(.K(8), .CNT_W(16)) bus ();
    secded_dec_pipe_if #(.K(8), .CNT_W(2))  bus_s ();

    secded_dec_pipe #(.K(8), .CNT_W(16)) dut   (.clk_i(clk), .rst_i(rst), .bus(bus.slave));
    secded_dec_pipe #(.K(8), .CNT_W(2))  dut_s (.clk_i(clk), .rst_i(rst), .bus(bus_s.slave));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [12:0] encode(input logic [7:0] dat);
        logic [12:0] cw;
        logic [3:0]  s;
        int          idx;
        cw  = '0;
        s   = '0;
        idx = 0;
        for (int p = 1; p <= 12; p++) begin
            if (p != 1 && p != 2 && p != 4 && p != 8) begin
                cw[p] = dat[idx];
                idx++;
            end
        end
        for (int p = 1; p <= 12; p++) if (cw[p]) s ^= 4'(p);
        cw[1] = s[0];
        cw[2] = s[1];
        cw[4] = s[2];
        cw[8] = s[3];
        cw[0] = ^cw[12:1];
        return cw;
    endfunction

    // One isolated word: accept, check exact 2-cycle latency and outputs, then handshake.
    task automatic run_word(input string tag, input logic [12:0] cw, input logic ce,
                            input logic [7:0] eq, input logic [3:0] es,
                            input logic esb, input logic edb, input logic efix,
                            input logic do_clr);
        check({tag, "_rdy"}, 32'(bus.d_ready_o), 32'd1);
        bus.d_i       = cw;
        bus.corr_en_i = ce;
        bus.d_valid_i = 1'b1;
        bus.q_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.d_valid_i = 1'b0;
        check({tag, "_early"}, 32'(bus.q_valid_o), 32'd0);
        @(posedge clk); #1;
        check({tag, "_vld"}, 32'(bus.q_valid_o), 32'd1);
        check({tag, "_q"},   32'(bus.q_o),        32'(eq));
        check({tag, "_syn"}, 32'(bus.syndrome_o), 32'(es));
        check({tag, "_sb"},  32'(bus.sb_err_o),   32'(esb));
        check({tag, "_db"},  32'(bus.db_err_o),   32'(edb));
        check({tag, "_fix"}, 32'(bus.sb_fix_o),   32'(efix));
        $display("txn %s cw=%03h ce=%0d q=%02h syn=%0h sb=%0d db=%0d fix=%0d", tag, cw, ce,
                 bus.q_o, bus.syndrome_o, bus.sb_err_o, bus.db_err_o, bus.sb_fix_o);
        bus.clr_i = do_clr;
        @(posedge clk); #1;
        bus.clr_i = 1'b0;
    endtask

    task automatic check_stats(input string tag, input int esb, input int edb,
                               input logic [3:0] efs, input logic efv);
        check({tag, "_sbcnt"}, 32'(bus.sb_cnt_o),    32'(esb));
        check({tag, "_dbcnt"}, 32'(bus.db_cnt_o),    32'(edb));
        check({tag, "_fsyn"},  32'(bus.first_syn_o), 32'(efs));
        check({tag, "_fvld"},  32'(bus.first_vld_o), 32'(efv));
    endtask

    logic [12:0] bp_cw   [10];
    logic [7:0]  bp_data [10];
    logic        p_rdy;
    logic        p_acc;
    logic        saw_stall;
    int          c_got;

    initial begin
        bus.d_i = '0;   bus.d_valid_i = 1'b0;   bus.corr_en_i = 1'b1;
        bus.q_ready_i = 1'b1;   bus.clr_i = 1'b0;
        bus_s.d_i = '0; bus_s.d_valid_i = 1'b0; bus_s.corr_en_i = 1'b1;
        bus_s.q_ready_i = 1'b1; bus_s.clr_i = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_qvld", 32'(bus.q_valid_o), 32'd0);
        check("rst_drdy", 32'(bus.d_ready_o), 32'd1);
        check("rst_q",    32'(bus.q_o),       32'd0);
        check("rst_flags", 32'({bus.sb_err_o, bus.db_err_o, bus.sb_fix_o}), 32'd0);
        check_stats("rst", 0, 0, 4'h0, 1'b0);
        rst = 1'b0;

        run_word("clean",   13'h05A, 1'b1, 8'h05, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_stats("clean", 0, 0, 4'h0, 1'b0);
        run_word("sb_fix",  13'h0DA, 1'b1, 8'h05, 4'h7, 1'b1, 1'b0, 1'b1, 1'b0);
        check_stats("sb_fix", 1, 0, 4'h7, 1'b1);
        run_word("sb_raw",  13'h0DA, 1'b0, 8'h0D, 4'h7, 1'b1, 1'b0, 1'b0, 1'b0);
        check_stats("sb_raw", 2, 0, 4'h7, 1'b1);
        run_word("par_err", 13'h05B, 1'b1, 8'h05, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        check_stats("par_err", 3, 0, 4'h7, 1'b1);
        run_word("db",      13'h0C5A, 1'b1, 8'h65, 4'h1, 1'b0, 1'b1, 1'b0, 1'b0);
        check_stats("db", 3, 1, 4'h7, 1'b1);
        // Three flips (positions 0,1,12): odd parity but syndrome 13 lies beyond N.
        run_word("syn_gt_n", 13'h1059, 1'b1, 8'h85, 4'hD, 1'b0, 1'b1, 1'b0, 1'b0);
        check_stats("syn_gt_n", 3, 2, 4'h7, 1'b1);
        run_word("clr_wins", 13'h0DA, 1'b1, 8'h05, 4'h7, 1'b1, 1'b0, 1'b1, 1'b1);
        check_stats("clr_wins", 0, 0, 4'h0, 1'b0);
        run_word("db_cap",  13'h0C5A, 1'b1, 8'h65, 4'h1, 1'b0, 1'b1, 1'b0, 1'b0);
        check_stats("db_cap", 0, 1, 4'h1, 1'b1);

        // Backpressure stream: odd words carry a single error at position 3.
        for (int i = 0; i < 10; i++) begin
            bp_data[i] = 8'(i * 29 + 7);
            bp_cw[i]   = encode(bp_data[i]) ^ ((i % 2 == 1) ? 13'h0008 : 13'h0000);
        end
        bus.clr_i = 1'b1;
        @(posedge clk); #1;
        bus.clr_i = 1'b0;
        saw_stall = 1'b0;
        c_got     = 0;
        bus.corr_en_i = 1'b1;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    bus.d_i       = bp_cw[i];
                    bus.d_valid_i = 1'b1;
                    p_acc         = 1'b0;
                    for (int w = 0; w < 50 && !p_acc; w++) begin
                        @(negedge clk);
                        p_rdy = bus.d_ready_o;
                        if (!p_rdy) saw_stall = 1'b1;
                        @(posedge clk); #1;
                        p_acc = p_rdy;
                    end
                    if (!p_acc) check("bp_accept_timeout", 32'd0, 32'd1);
                end
                bus.d_valid_i = 1'b0;
            end
            begin
                for (int c = 0; c < 200 && c_got < 10; c++) begin
                    @(negedge clk);
                    if (bus.q_valid_o) begin
                        check("bp_word", 32'(bus.q_o), 32'(bp_data[c_got]));
                        if (bus.q_ready_i) begin
                            $display("txn bp idx=%0d q=%02h sb=%0d", c_got, bus.q_o, bus.sb_err_o);
                            c_got++;
                        end
                    end
                    @(posedge clk); #1;
                    bus.q_ready_i = !(c >= 2 && c < 7);
                end
            end
        join
        check("bp_count", 32'(c_got), 32'd10);
        check("bp_stall", 32'(saw_stall), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("bp_idle", 32'(bus.q_valid_o), 32'd0);
        check_stats("bp", 5, 0, 4'h3, 1'b1);

        // Reset while words are in flight.
        bus.d_i = 13'h0DA; bus.d_valid_i = 1'b1; bus.q_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.d_valid_i = 1'b0;
        check("mid_rst_qvld", 32'(bus.q_valid_o), 32'd0);
        check_stats("mid_rst", 0, 0, 4'h0, 1'b0);
        @(posedge clk); #1;
        check("mid_rst_qvld2", 32'(bus.q_valid_o), 32'd0);
        @(posedge clk); #1;
        check("mid_rst_qvld3", 32'(bus.q_valid_o), 32'd0);

        // Saturation on the narrow-counter instance.
        bus_s.d_i = 13'h0DA; bus_s.corr_en_i = 1'b1; bus_s.q_ready_i = 1'b1;
        bus_s.d_valid_i = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        bus_s.d_valid_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        $display("txn sat sb_cnt=%0d", bus_s.sb_cnt_o);
        check("sat_sbcnt", 32'(bus_s.sb_cnt_o), 32'd3);
        check("sat_dbcnt", 32'(bus_s.db_cnt_o), 32'd0);
        check("sat_fvld",  32'(bus_s.first_vld_o), 32'd1);
        bus_s.clr_i = 1'b1;
        @(posedge clk); #1;
        bus_s.clr_i = 1'b0;
        check("sat_clr_sbcnt", 32'(bus_s.sb_cnt_o), 32'd0);
        check("sat_clr_fvld",  32'(bus_s.first_vld_o), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/secded_dec_pipe.md
Name: secded_dec_pipe

Overview:
- Parametrised, pipelined Hamming SECDED decoder.
- Successor to the combinational 8-bit decoder; any K, with valid/ready streaming, a correction-enable mode, saturating error counters and first-error syndrome capture.
- Sits between the memory/link read path and the consumer.
- Two-cycle latency, full throughput, backpressure-safe.

Parameters:
- K, 8, information bits.
- M, smallest m with 2**m >= m+K+1 (8 -> 4), Hamming check bits; derived, not overridden.
- N, M+K, Hamming code length excluding the overall parity bit.
- CNT_W, 16, width of each error counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- d_i  in  N+1  codeword.
- d_valid_i  in  1  codeword valid.
- d_ready_o  out  1  decoder can accept.
- corr_en_i  in  1  1 = correct single errors; 0 = detect only. Sampled with d_i.
- q_o  out  K  decoded data.
- q_valid_o  out  1  output valid.
- q_ready_i  in  1  consumer accepts.
- syndrome_o  out  M  syndrome of the word on q_o.
- sb_err_o  out  1  single-bit error detected.
- db_err_o  out  1  double-bit error detected.
- sb_fix_o  out  1  single error corrected.
- clr_i  in  1  clear counters and capture.
- sb_cnt_o  out  CNT_W  count of delivered sb_err words, saturating.
- db_cnt_o  out  CNT_W  count of delivered db_err words, saturating.
- first_syn_o  out  M  syndrome of the first errored word since clear.
- first_vld_o  out  1  first_syn_o holds a capture.

Behaviour:
- Codeword layout:
  - d_i[0] is the overall parity: XOR of d_i[N:1] equals d_i[0].
  - d_i[p] for p = 1..N is Hamming position p. Check bits sit at power-of-two positions.
  - Data bits fill the remaining positions ascending: lowest position -> q[0].
- Syndrome and overall parity:
  - syndrome = XOR of all positions p with d_i[p]=1.
  - par = XOR of d_i[N:0].
- Classification:
  - syn=0, par=0: clean.
  - par=1: single error, sb_err=1. Position = syn; syn=0 means the overall parity bit itself is in error. Syn > N is reported as db_err.
  - syn!=0, par=0: double error, db_err=1. Data is passed raw.
- Correction:
  - Only when sb_err and corr_en: flip position syn, sb_fix=1.
  - corr_en=0: data raw, sb_fix=0, flags still reported.
- Pipeline:
  - S1 registers the codeword, syndrome, par and corr_en.
  - S2 registers q and the flags.
  - Latency is 2 cycles from accept to q_valid_o.
  - Each stage loads when it is empty or its content leaves this cycle.
  - d_ready_o = !S1_valid || S1 advances. Combinational from q_ready_i; no bubbles at full rate.
  - Output holds stable while q_valid_o=1 && q_ready_i=0.
- Counters:
  - Increment on handshake (q_valid_o && q_ready_i) with the corresponding flag.
  - Saturate at 2**CNT_W-1.
  - clr_i wins over a simultaneous increment: result 0.
- Capture:
  - On the first handshake with sb_err or db_err while first_vld_o=0: latch the syndrome, set first_vld_o.
  - Later errors ignored. clr_i clears both. Same-cycle clr_i and error: clear wins.
- Reset:
  - All valids 0, d_ready_o=1 after reset, q_o/syndrome_o/flags 0, counters 0, first_syn_o 0, first_vld_o 0.
  - Reset mid-stream discards in-flight words; nothing is delivered from before reset.

Test Plan:
- Clean word, K=8: d_i=13'h05A, corr_en=1 -> two cycles later q_o=8'h05, syndrome_o=0, all flags 0, counters unchanged.
- Single data error: d_i=13'h0DA -> q_o=8'h05, syndrome_o=4'b0111, sb_err_o=1, sb_fix_o=1, sb_cnt_o=1, first_syn_o=4'b0111, first_vld_o=1.
- Same word with corr_en=0 -> q_o=8'h0D, sb_err_o=1, sb_fix_o=0.
- Overall parity bit error: d_i=13'h05B -> q_o=8'h05, syndrome_o=0, sb_err_o=1, sb_fix_o=1.
- Double error: d_i=13'h0C5A -> q_o=8'h65, syndrome_o=4'b0001, db_err_o=1, sb_err_o=0, db_cnt_o increments.
- Backpressure: stream 10 words, hold q_ready_i=0 for 5 cycles -> d_ready_o drops after 2 more accepts. No loss or duplication; output order matches input; counters count each word once.
- Saturation with CNT_W=2: 5 single-error words -> sb_cnt_o=3. Then clr_i -> 0.
- Reset mid-stream -> no q_valid_o on the next cycle, counters 0.
